// File: rtl/fifo_rr_arbiter.sv
// fifo_rr_arbiter: round-robin reader of four FIFO channels into a single registered output word.
// Define FIFO_ARB_BURST_EN to let one grant move up to BURST_LEN consecutive words.
module fifo_rr_arbiter #(
   parameter int DWIDTH    = 32,
   parameter int BURST_LEN = 4
) (
   input  logic              clk,
   input  logic              rst,
   output logic [3:0]        req_in,
   input  logic [3:0]        ack_in,
   input  logic [DWIDTH-1:0] data_in0,
   input  logic [DWIDTH-1:0] data_in1,
   input  logic [DWIDTH-1:0] data_in2,
   input  logic [DWIDTH-1:0] data_in3,
   input  logic [3:0]        fifo_empty,
   output logic              req_out,
   input  logic              ack_out,
   output logic [DWIDTH-1:0] data_out,
   output logic [1:0]        grant
);

   typedef enum logic [1:0] {IDLE, FETCH, SEND} state_t;

   state_t            state_q, state_d;
   logic [3:0]        req_in_q, req_in_d;
   logic              req_out_q, req_out_d;
   logic [DWIDTH-1:0] data_out_q, data_out_d;
   logic [1:0]        grant_q, grant_d;
   logic [1:0]        last_q, last_d;

   logic [DWIDTH-1:0] data_arr [4];
   logic [DWIDTH-1:0] data_sel;
   logic              sel_found;
   logic [1:0]        sel_idx;
   logic [1:0]        cand;

`ifdef FIFO_ARB_BURST_EN
   localparam int CW = $clog2(BURST_LEN + 1);
   localparam logic [CW-1:0] BURST_MAX = CW'(BURST_LEN - 1);

   logic [CW-1:0] burst_cnt_q, burst_cnt_d;
   logic          burst_go;

   // Stay on the same channel only while it still has data and the burst is not used up.
   assign burst_go = (burst_cnt_q < BURST_MAX) && !fifo_empty[grant_q];
`endif

   assign data_arr[0] = data_in0;
   assign data_arr[1] = data_in1;
   assign data_arr[2] = data_in2;
   assign data_arr[3] = data_in3;
   assign data_sel    = data_arr[grant_q];

   // Scan starts one past the last served channel, so every channel waits at most 4 grants.
   always_comb begin
      sel_found = 1'b0;
      sel_idx   = 2'd0;
      cand      = 2'd0;
      for (int k = 1; k <= 4; k++) begin
         cand = last_q + 2'(k);
         if (!sel_found && !fifo_empty[cand]) begin
            sel_found = 1'b1;
            sel_idx   = cand;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE: begin
            if (sel_found) state_d = FETCH;
         end
         FETCH: begin
            if (ack_in[grant_q])         state_d = SEND;
            else if (fifo_empty[grant_q]) state_d = IDLE;
         end
         SEND: begin
            if (ack_out) begin
`ifdef FIFO_ARB_BURST_EN
               state_d = burst_go ? FETCH : IDLE;
`else
               state_d = IDLE;
`endif
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_comb begin
      req_in_d   = req_in_q;
      req_out_d  = req_out_q;
      data_out_d = data_out_q;
      grant_d    = grant_q;
      last_d     = last_q;
`ifdef FIFO_ARB_BURST_EN
      burst_cnt_d = burst_cnt_q;
`endif
      case (state_q)
         IDLE: begin
            req_in_d = 4'b0000;
            if (sel_found) begin
               grant_d           = sel_idx;
               req_in_d[sel_idx] = 1'b1;
            end
         end
         FETCH: begin
            if (ack_in[grant_q]) begin
               data_out_d = data_sel;
               req_in_d   = 4'b0000;
               req_out_d  = 1'b1;
            end else if (fifo_empty[grant_q]) begin
               // Aborted fetch: last stays put so this channel keeps its turn.
               req_in_d = 4'b0000;
`ifdef FIFO_ARB_BURST_EN
               burst_cnt_d = '0;
`endif
            end
         end
         SEND: begin
            if (ack_out) begin
               req_out_d = 1'b0;
`ifdef FIFO_ARB_BURST_EN
               if (burst_go) begin
                  req_in_d[grant_q] = 1'b1;
                  burst_cnt_d       = burst_cnt_q + CW'(1);
               end else begin
                  last_d      = grant_q;
                  burst_cnt_d = '0;
               end
`else
               last_d = grant_q;
`endif
            end
         end
         default: begin
            req_in_d  = 4'b0000;
            req_out_d = 1'b0;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         req_in_q   <= 4'b0000;
         req_out_q  <= 1'b0;
         data_out_q <= '0;
         grant_q    <= 2'd0;
         last_q     <= 2'd3;
`ifdef FIFO_ARB_BURST_EN
         burst_cnt_q <= '0;
`endif
      end else begin
         req_in_q   <= req_in_d;
         req_out_q  <= req_out_d;
         data_out_q <= data_out_d;
         grant_q    <= grant_d;
         last_q     <= last_d;
`ifdef FIFO_ARB_BURST_EN
         burst_cnt_q <= burst_cnt_d;
`endif
      end
   end

   assign req_in   = req_in_q;
   assign req_out  = req_out_q;
   assign data_out = data_out_q;
   assign grant    = grant_q;

endmodule

// File: tb/tb_fifo_rr_arbiter.sv
// tb_fifo_rr_arbiter: directed-vector bench for fifo_rr_arbiter (burst scenario only when FIFO_ARB_BURST_EN is defined).
`timescale 1ns/1ps
module tb_fifo_rr_arbiter;

   localparam logic [31:0] D0 = 32'h1111_0000;
   localparam logic [31:0] D1 = 32'h2222_1111;
   localparam logic [31:0] D2 = 32'hA5A5_A5A5;
   localparam logic [31:0] D3 = 32'h3333_4444;

   logic        clk = 1'b0;
   logic        rst;
   logic [3:0]  req_in;
   logic [3:0]  ack_in;
   logic [31:0] data_in0, data_in1, data_in2, data_in3;
   logic [3:0]  fifo_empty;
   logic        req_out;
   logic        ack_out;
   logic [31:0] data_out;
   logic [1:0]  grant;

   int checks = 0;
   int errors = 0;

   fifo_rr_arbiter #(.DWIDTH(32), .BURST_LEN(4)) dut (
      .clk(clk), .rst(rst), .req_in(req_in), .ack_in(ack_in),
      .data_in0(data_in0), .data_in1(data_in1), .data_in2(data_in2), .data_in3(data_in3),
      .fifo_empty(fifo_empty), .req_out(req_out), .ack_out(ack_out),
      .data_out(data_out), .grant(grant)
   );

   always #5 clk = ~clk;

   // Advance one rising edge; outputs are read and inputs changed 1 ns later.
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      rst = 1'b1; fifo_empty = 4'hF; ack_in = 4'h0; ack_out = 1'b0;
      step(); step();
      rst = 1'b0;
   endtask

   task automatic test_reset();
      do_reset();
      checks++; if (req_in !== 4'b0000) begin errors++; $display("FAIL reset_req_in got %b want 0000", req_in); end
      checks++; if (req_out !== 1'b0) begin errors++; $display("FAIL reset_req_out got %b want 0", req_out); end
      checks++; if (grant !== 2'd0) begin errors++; $display("FAIL reset_grant got %0d want 0", grant); end
      checks++; if (data_out !== 32'h0) begin errors++; $display("FAIL reset_data_out got %h want 0", data_out); end
      step();
      checks++; if (req_in !== 4'b0000) begin errors++; $display("FAIL idle_empty_req_in got %b want 0000", req_in); end
   endtask

   task automatic test_round_robin();
      logic [1:0]  exp_g [5] = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0};
      logic [31:0] exp_d [4] = '{D0, D1, D2, D3};
      logic [3:0]  exp_r;
      do_reset();
      fifo_empty = 4'h0; ack_in = 4'hF; ack_out = 1'b1;
      for (int w = 0; w < 5; w++) begin
         exp_r = 4'b0001 << exp_g[w];
         step();
         checks++; if (grant !== exp_g[w]) begin errors++; $display("FAIL rr_grant[%0d] got %0d want %0d", w, grant, exp_g[w]); end
         checks++; if (req_in !== exp_r) begin errors++; $display("FAIL rr_req_in[%0d] got %b want %b", w, req_in, exp_r); end
         step();
         checks++; if (req_out !== 1'b1 || data_out !== exp_d[exp_g[w]]) begin errors++;
            $display("FAIL rr_word[%0d] got req_out=%b data=%h want 1 %h", w, req_out, data_out, exp_d[exp_g[w]]); end
         $display("word %0d grant %0d data %h", w, grant, data_out);
         step();
         checks++; if (req_out !== 1'b0) begin errors++; $display("FAIL rr_release[%0d] got %b want 0", w, req_out); end
      end
   endtask

   task automatic test_single_and_backpressure();
      do_reset();
      fifo_empty = 4'b1011; ack_in = 4'hF; ack_out = 1'b0;
      step();
      checks++; if (req_in !== 4'b0100 || grant !== 2'd2) begin errors++;
         $display("FAIL single_select got req_in=%b grant=%0d want 0100 2", req_in, grant); end
      step();
      checks++; if (req_out !== 1'b1 || data_out !== D2 || grant !== 2'd2) begin errors++;
         $display("FAIL single_word got %b %h %0d want 1 %h 2", req_out, data_out, grant, D2); end
      for (int c = 0; c < 5; c++) begin
         step();
         checks++; if (req_out !== 1'b1 || data_out !== D2 || req_in !== 4'b0000) begin errors++;
            $display("FAIL backpressure[%0d] got %b %h %b want 1 %h 0000", c, req_out, data_out, req_in, D2); end
      end
      ack_out = 1'b1;
      step();
      checks++; if (req_out !== 1'b0) begin errors++; $display("FAIL bp_release got %b want 0", req_out); end
      $display("word bp grant %0d data %h", grant, data_out);
      step();
      checks++; if (grant !== 2'd2 || req_in !== 4'b0100) begin errors++;
         $display("FAIL single_again got %0d %b want 2 0100", grant, req_in); end
   endtask

   task automatic test_abort();
      do_reset();
      fifo_empty = 4'b1110; ack_in = 4'hF; ack_out = 1'b1;
      step(); step(); step();
      fifo_empty = 4'b1101; ack_in = 4'h0;
      step();
      checks++; if (grant !== 2'd1 || req_in !== 4'b0010) begin errors++;
         $display("FAIL abort_sel1 got %0d %b want 1 0010", grant, req_in); end
      fifo_empty = 4'b1110; ack_in = 4'b1101;
      step();
      checks++; if (req_in !== 4'b0000 || req_out !== 1'b0) begin errors++;
         $display("FAIL abort_idle got %b %b want 0000 0", req_in, req_out); end
      fifo_empty = 4'b1100; ack_in = 4'h0;
      step();
      checks++; if (grant !== 2'd1 || req_in !== 4'b0010) begin errors++;
         $display("FAIL abort_retry got %0d %b want 1 0010", grant, req_in); end
      fifo_empty = 4'b1010; ack_in = 4'b1101;
      step();
      checks++; if (req_in !== 4'b0000 || req_out !== 1'b0) begin errors++;
         $display("FAIL abort2_idle got %b %b want 0000 0", req_in, req_out); end
      step();
      checks++; if (grant !== 2'd2 || req_in !== 4'b0100) begin errors++;
         $display("FAIL abort_next got %0d %b want 2 0100", grant, req_in); end
      step();
      checks++; if (req_out !== 1'b1 || data_out !== D2) begin errors++;
         $display("FAIL abort_word got %b %h want 1 %h", req_out, data_out, D2); end
   endtask

   task automatic test_reset_mid_send();
      do_reset();
      fifo_empty = 4'b1101; ack_in = 4'hF; ack_out = 1'b0;
      step(); step();
      checks++; if (req_out !== 1'b1 || grant !== 2'd1) begin errors++;
         $display("FAIL pre_reset_send got %b %0d want 1 1", req_out, grant); end
      rst = 1'b1; fifo_empty = 4'h0;
      for (int c = 0; c < 2; c++) begin
         step();
         checks++; if (req_out !== 1'b0 || req_in !== 4'b0000 || grant !== 2'd0 || data_out !== 32'h0) begin errors++;
            $display("FAIL midsend_reset[%0d] got %b %b %0d %h want 0 0000 0 0", c, req_out, req_in, grant, data_out); end
      end
      rst = 1'b0; ack_out = 1'b1;
      step();
      checks++; if (grant !== 2'd0 || req_in !== 4'b0001) begin errors++;
         $display("FAIL post_reset_first got %0d %b want 0 0001", grant, req_in); end
   endtask

`ifdef FIFO_ARB_BURST_EN
   task automatic test_burst();
      do_reset();
      fifo_empty = 4'b1100; ack_in = 4'hF; ack_out = 1'b1;
      step();
      for (int w = 0; w < 4; w++) begin
         step();
         checks++; if (req_out !== 1'b1 || data_out !== D0 || grant !== 2'd0) begin errors++;
            $display("FAIL burst_word[%0d] got %b %h %0d want 1 %h 0", w, req_out, data_out, grant, D0); end
         $display("burst word %0d data %h", w, data_out);
         if (w < 3) begin
            step();
            checks++; if (req_in !== 4'b0001 || req_out !== 1'b0) begin errors++;
               $display("FAIL burst_fetch[%0d] got %b %b want 0001 0", w, req_in, req_out); end
         end
      end
      step(); step();
      checks++; if (grant !== 2'd1 || req_in !== 4'b0010) begin errors++;
         $display("FAIL burst_rotate got %0d %b want 1 0010", grant, req_in); end
   endtask
`endif

   initial begin
      #200000;
      $display("FAIL watchdog expired");
      $fatal(1, "watchdog");
   end

   initial begin
      data_in0 = D0; data_in1 = D1; data_in2 = D2; data_in3 = D3;
      rst = 1'b1; fifo_empty = 4'hF; ack_in = 4'h0; ack_out = 1'b0;
      test_reset();
      test_round_robin();
      test_single_and_backpressure();
      test_abort();
      test_reset_mid_send();
`ifdef FIFO_ARB_BURST_EN
      test_burst();
`endif
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/fifo_rr_arbiter.md
FIFO_RR_ARBITER -- requirements
Module: fifo_rr_arbiter

Interface
REQ-001 SHALL have parameter DWIDTH, default 32, the data word width.
REQ-002 SHALL have parameter BURST_LEN, default 4, the maximum consecutive words per grant; it is used only when FIFO_ARB_BURST_EN is defined.
REQ-003 SHALL have port clk, input, 1 bit, the single clock; all logic is on the rising edge.
REQ-004 SHALL have port rst, input, 1 bit, a synchronous active-high reset.
REQ-005 SHALL have port req_in, output, 4 bits, the read request to FIFO channel i (bit i).
REQ-006 SHALL have port ack_in, input, 4 bits, the read acknowledge from FIFO channel i.
REQ-007 SHALL have ports data_in0..data_in3, input, DWIDTH each, the read data of channels 0..3.
REQ-008 SHALL have port fifo_empty, input, 4 bits, the empty flag of FIFO channel i.
REQ-009 SHALL have port req_out, output, 1 bit, which flags a valid word on data_out.
REQ-010 SHALL have port ack_out, input, 1 bit, the consumer acknowledge.
REQ-011 SHALL have port data_out, output, DWIDTH, the held word.
REQ-012 SHALL have port grant, output, 2 bits, the index of the channel currently owned.

Function
REQ-013 SHALL register every output; no combinational path runs from an input to an output.
REQ-014 SHALL implement the FSM states IDLE, FETCH and SEND.
REQ-015 SHALL complete a transfer on any edge where req and ack are both high on the same link.
REQ-016 In IDLE, SHALL scan channels in the order last+1, last+2, last+3, last+4 (mod 4) and select the first one with fifo_empty low, where last is the last served channel.
REQ-017 On a selection in IDLE, SHALL set grant to g and req_in[g] to 1, then enter FETCH.
REQ-018 In IDLE with all fifo_empty bits high, SHALL remain in IDLE with req_in set to 0.
REQ-019 In FETCH, on ack_in[g] high, SHALL latch data_in{g} into data_out, clear req_in[g], set req_out, and enter SEND.
REQ-020 In FETCH, if fifo_empty[g] is high and ack_in[g] is low, SHALL clear req_in[g], return to IDLE, and leave last unchanged.
REQ-021 SHALL ignore ack_in bits of non-granted channels and SHALL ignore ack_out while req_out is low.
REQ-022 In SEND, SHALL hold data_out and req_out stable until ack_out is high.
REQ-023 On the ack_out edge, SHALL clear req_out, set last to g, and enter IDLE (rotation after every word).
REQ-024 SHALL never assert more than one req_in bit, and SHALL never assert req_in while req_out is high in non-burst mode.
REQ-025 SHALL have a minimum per-word cost of 3 cycles (IDLE, FETCH, SEND) with an immediate ack_in and ack_out.
REQ-026 SHALL guarantee that a continuously non-empty channel is served within 4 grants (no starvation).

Reset
REQ-027 On rst high at an edge, SHALL force req_in=0, req_out=0, data_out=0, grant=0, last=3, burst count=0, and state IDLE, regardless of the current state.
REQ-028 On reset during FETCH or SEND, SHALL discard the pending word; the first arbitration after reset starts at channel 0.
REQ-029 SHALL drive no request in the reset cycle itself; arbitration begins in the first cycle with rst low.

Configuration
REQ-030 With FIFO_ARB_BURST_EN defined, on the SEND ack_out edge, if the burst count is below BURST_LEN-1 and fifo_empty[g] is low, SHALL go directly to FETCH, set req_in[g]=1, and increment the count (2 cycles/word).
REQ-031 With FIFO_ARB_BURST_EN defined, otherwise SHALL proceed per REQ-023 and clear the burst count; the count also clears on a FETCH abort.
REQ-032 Without FIFO_ARB_BURST_EN, SHALL contain no burst counter, and BURST_LEN SHALL have no effect.

Verification
REQ-033 Reset: rst held 2 cycles mid-SEND -> the next cycle shows req_out=0, req_in=0, grant=0, with channel 0 served first afterwards.
REQ-034 All channels non-empty with immediate acks -> grant sequence 0,1,2,3,0 and one data_out word every 3 cycles.
REQ-035 Only channel 2 non-empty holding 0xA5A5A5A5 -> req_in=4'b0100, then req_out=1 with data_out=0xA5A5A5A5 and grant=2.
REQ-036 Backpressure: ack_out held low 5 cycles -> data_out and req_out are stable, all req_in=0, and the word transfers on the first ack_out.
REQ-037 Abort: fifo_empty[1] rises during FETCH with ack_in[1]=0 -> return to IDLE, next grant to channel 2 if it is non-empty, otherwise channel 1 is retried.
REQ-038 FIFO_ARB_BURST_EN defined, BURST_LEN=4, channels 0 and 1 always non-empty -> 4 words from channel 0 at 2 cycles/word, then grant=1.
